uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one `uarttx` transmitter between `NREQ` byte requesters. It arbitrates pending requests and captures the winning byte. It then sequences the transmitter's `newd`/`dintx` handshake by watching the serial line and `donetx`, and reports completion or timeout per requester. It sits in the `clk` domain between client logic and `uart_top`'s transmit inputs.

---
 rtl/uart_tx_sched.sv | 216 +++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter between NREQ byte
// requesters. It grants one pending request per IDLE visit, holds newd until the start bit
// appears on the line, then waits for donetx to rise and fall before serving the next one.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   req_i        per-requester request, held until the matching ack
//   req_data_i   byte i is req_data_i[8i+7:8i]
//   ack_o        one-cycle pulse when a requester's byte is captured
//   cmpl_o       one-cycle pulse when a frame finishes (donetx seen)
//   err_o        one-cycle pulse on a wait-state timeout
//   evt_id_o     requester id qualifying cmpl_o / err_o
//   busy_o       high in every state except idle
//   cur_id_o     id of the requester currently being served
//   tx_newd_o    transmitter newd
//   tx_data_o    transmitter dintx
//   tx_line_i    transmitter serial output, used for start-bit detection
//   tx_done_i    transmitter donetx
module uart_tx_sched #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned GAP_CYCLES = 0,
    localparam int unsigned IDW       = $clog2(NREQ)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] req_data_i,
    output logic [NREQ-1:0]   ack_o,
    output logic              cmpl_o,
    output logic              err_o,
    output logic [IDW-1:0]    evt_id_o,
    output logic              busy_o,
    output logic [IDW-1:0]    cur_id_o,
    output logic              tx_newd_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_line_i,
    input  logic              tx_done_i
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    // +2 keeps the gap counter at least one bit wide when GAP_CYCLES is 0
    localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GapLast   = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitStart,
        StWaitDone,
        StWaitIdle,
        StGap
    } state_e;

    // State after a frame ends, normally or by timeout
    localparam state_e AfterFrame = (GAP_CYCLES > 0) ? StGap : StIdle;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              cmpl_q, cmpl_d;
    logic              err_q, err_d;
    logic [IDW-1:0]    evt_id_q, evt_id_d;
    logic              busy_q, busy_d;
    logic [IDW-1:0]    cur_id_q, cur_id_d;
    logic              newd_q, newd_d;
    logic [7:0]        data_q, data_d;

    logic              grant_valid;
    logic [IDW-1:0]    grant_id;
    logic              timed_out;

    assign timed_out = (timer_q == TimerLast);

    // First asserted request scanning upward from the pointer, with wrap-around
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!grant_valid && req_i[IDW'(idx)]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        gap_d    = gap_q;
        ack_d    = '0;
        cmpl_d   = 1'b0;
        err_d    = 1'b0;
        evt_id_d = evt_id_q;
        cur_id_d = cur_id_q;
        newd_d   = newd_q;
        data_d   = data_q;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    ack_d[grant_id] = 1'b1;
                    data_d          = req_data_i[32'(grant_id) * 8 +: 8];
                    newd_d          = 1'b1;
                    cur_id_d        = grant_id;
                    ptr_d           = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    timer_d         = '0;
                    state_d         = StWaitStart;
                end
            end
            StWaitStart: begin
                if (!tx_line_i) begin
                    newd_d  = 1'b0;
                    timer_d = '0;
                    state_d = StWaitDone;
                end else if (timed_out) begin
                    err_d    = 1'b1;
                    evt_id_d = cur_id_q;
                    newd_d   = 1'b0;
                    gap_d    = '0;
                    state_d  = AfterFrame;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (tx_done_i) begin
                    cmpl_d   = 1'b1;
                    evt_id_d = cur_id_q;
                    timer_d  = '0;
                    state_d  = StWaitIdle;
                end else if (timed_out) begin
                    err_d    = 1'b1;
                    evt_id_d = cur_id_q;
                    newd_d   = 1'b0;
                    gap_d    = '0;
                    state_d  = AfterFrame;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitIdle: begin
                if (!tx_done_i) begin
                    gap_d   = '0;
                    state_d = AfterFrame;
                end else if (timed_out) begin
                    err_d    = 1'b1;
                    evt_id_d = cur_id_q;
                    newd_d   = 1'b0;
                    gap_d    = '0;
                    state_d  = AfterFrame;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            timer_q  <= '0;
            gap_q    <= '0;
            ack_q    <= '0;
            cmpl_q   <= 1'b0;
            err_q    <= 1'b0;
            evt_id_q <= '0;
            busy_q   <= 1'b0;
            cur_id_q <= '0;
            newd_q   <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            ack_q    <= ack_d;
            cmpl_q   <= cmpl_d;
            err_q    <= err_d;
            evt_id_q <= evt_id_d;
            busy_q   <= busy_d;
            cur_id_q <= cur_id_d;
            newd_q   <= newd_d;
            data_q   <= data_d;
        end
    end

    assign ack_o     = ack_q;
    assign cmpl_o    = cmpl_q;
    assign err_o     = err_q;
    assign evt_id_o  = evt_id_q;
    assign busy_o    = busy_q;
    assign cur_id_o  = cur_id_q;
    assign tx_newd_o = newd_q;
    assign tx_data_o = data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a behavioural transmitter answers newd with a serial frame and a
// donetx pulse; expected ack/cmpl/err events and frame bytes are queued as stimulus is issued
// and popped by independent monitors.
module tb_uart_tx_sched;

    localparam int unsigned Timeout   = 64;
    localparam int unsigned GapCycles = 10;
    localparam int          BitClk    = 4;

    localparam logic [1:0] KAck  = 2'd0;
    localparam logic [1:0] KCmpl = 2'd1;
    localparam logic [1:0] KErr  = 2'd2;
    localparam logic [1:0] KNone = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] id;
        logic [7:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  hold;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        cmpl, err, busy, tx_newd;
    logic [1:0]  evt_id, cur_id;
    logic [7:0]  tx_data;
    logic        tx_line = 1'b1;
    logic        tx_done = 1'b0;
    logic        tx_busy = 1'b0;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fall_cyc = 0;
    int ack_seen = 0;

    ev_t        exp_q[$];
    logic [7:0] frm_q[$];

    uart_tx_sched #(
        .NREQ      (4),
        .TIMEOUT   (Timeout),
        .GAP_CYCLES(GapCycles)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .req_data_i(req_data),
        .ack_o     (ack),
        .cmpl_o    (cmpl),
        .err_o     (err),
        .evt_id_o  (evt_id),
        .busy_o    (busy),
        .cur_id_o  (cur_id),
        .tx_newd_o (tx_newd),
        .tx_data_o (tx_data),
        .tx_line_i (tx_line),
        .tx_done_i (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input int id, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.id   = 2'(id);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // A normally completing transfer: ack, serial frame, cmpl
    task automatic exp_frame(input int id, input logic [7:0] data);
        push_ev(KAck, id, data);
        push_ev(KCmpl, id, 8'h00);
        frm_q.push_back(data);
    endtask

    task automatic sb_pop(input logic [1:0] kind, output ev_t e);
        if (exp_q.size() == 0) begin
            e.kind = KNone;
            e.id   = 2'd0;
            e.data = 8'h00;
        end else begin
            e = exp_q.pop_front();
        end
        chk("sb_event_kind", 32'(kind), 32'(e.kind));
    endtask

    // Transmitter model: 2-cycle latency, start bit, 8 data bits LSB first, stop bit, 2-cycle done
    initial begin : tx_model
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (tx_newd === 1'b1 && !stall) begin
                tx_busy = 1'b1;
                d = tx_data;
                repeat (2) @(negedge clk);
                tx_line = 1'b0;
                repeat (BitClk) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    tx_line = d[i];
                    repeat (BitClk) @(negedge clk);
                end
                tx_line = 1'b1;
                repeat (BitClk) @(negedge clk);
                tx_done = 1'b1;
                repeat (2) @(negedge clk);
                tx_done  = 1'b0;
                fall_cyc = cyc;
                tx_busy  = 1'b0;
            end
        end
    end

    // Serial frame decoder, sampling mid-bit
    initial begin : frame_mon
        logic [7:0] b;
        logic [7:0] x;
        forever begin
            do @(posedge clk); while (tx_line !== 1'b0);
            repeat (2) @(posedge clk);
            chk("frame_start_bit", 32'(tx_line), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (BitClk) @(posedge clk);
                b[i] = tx_line;
            end
            repeat (BitClk) @(posedge clk);
            chk("frame_stop_bit", 32'(tx_line), 32'd1);
            chk("frame_was_expected", 32'(frm_q.size() != 0), 32'd1);
            if (frm_q.size() != 0) begin
                x = frm_q.pop_front();
                chk("frame_data", 32'(b), 32'(x));
            end
        end
    end

    // Event monitor; also drops a requester's req on its own ack unless held
    initial begin : ev_mon
        ev_t e;
        forever begin
            @(negedge clk);
            if (cmpl || err) chk("cmpl_err_exclusive", 32'(cmpl & err), 32'd0);
            if (ack != 4'b0000) begin
                sb_pop(KAck, e);
                chk("ack_onehot", 32'(ack), 32'(4'b0001 << e.id));
                chk("ack_data", 32'(tx_data), 32'(e.data));
                chk("ack_cur_id", 32'(cur_id), 32'(e.id));
                chk("ack_newd_busy", 32'({tx_newd, busy}), 32'b11);
                req      = req & ~(ack & ~hold);
                ack_seen = ack_seen + 1;
            end
            if (cmpl) begin
                sb_pop(KCmpl, e);
                chk("cmpl_evt_id", 32'(evt_id), 32'(e.id));
                chk("cmpl_busy", 32'(busy), 32'd1);
            end
            if (err) begin
                sb_pop(KErr, e);
                chk("err_evt_id", 32'(evt_id), 32'(e.id));
                chk("err_newd_low", 32'(tx_newd), 32'd0);
            end
        end
    end

    task automatic chk_reset();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_cmpl", 32'(cmpl), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_evt_id", 32'(evt_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur_id", 32'(cur_id), 32'd0);
        chk("rst_tx_newd", 32'(tx_newd), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((busy || tx_busy || exp_q.size() != 0 || frm_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(!busy && !tx_busy && exp_q.size() == 0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Polls a DUT output bit at negedges; a missed bound counts as a failure
    task automatic wait_ack(input int id, input int limit, input string name);
        int n;
        n = 0;
        while (ack[id] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(ack[id]), 32'd1);
    endtask

    // Grant one requester, reset it while its frame is in flight, then let the line settle
    task automatic reset_mid_frame(input int id);
        int n;
        push_ev(KAck, id, req_data[8*id +: 8]);
        frm_q.push_back(req_data[8*id +: 8]);
        req = 4'(1 << id);
        @(negedge clk);
        wait_ack(id, 20, "rmf_ack");
        n = 0;
        while (tx_newd === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rmf_start_seen", 32'(tx_newd), 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset();
        n = 0;
        while (tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rmf_line_idle", 32'(tx_busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int ack_cyc;
        int base;
        rst      = 1'b1;
        req      = 4'b0000;
        hold     = 4'b0000;
        stall    = 1'b0;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        @(negedge clk);

        // Round-robin order from pointer 0
        exp_frame(0, 8'h11);
        exp_frame(1, 8'h22);
        exp_frame(3, 8'h44);
        req = 4'b1011;
        wait_quiet("rr_complete");

        // Fairness: all held for 8 frames
        hold = 4'b1111;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) exp_frame(i, req_data[8*i +: 8]);
        base = ack_seen;
        req  = 4'b1111;
        n = 0;
        while (ack_seen < base + 8 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        req  = 4'b0000;
        hold = 4'b0000;
        chk("fair_eight_acks", 32'(ack_seen - base), 32'd8);
        wait_quiet("fair_complete");

        // Single request with 0xA5
        req_data[23:16] = 8'hA5;
        exp_frame(2, 8'hA5);
        req = 4'b0100;
        wait_quiet("single_complete");
        chk("single_busy_low", 32'(busy), 32'd0);

        // Timeout: line never shows a start bit
        stall = 1'b1;
        push_ev(KAck, 1, 8'h22);
        push_ev(KErr, 1, 8'h00);
        req = 4'b0010;
        @(negedge clk);
        wait_ack(1, 20, "to_ack");
        n = 0;
        while (tx_newd === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("to_newd_cycles", 32'(n), Timeout);
        chk("to_err_pulse", 32'(err), 32'd1);
        wait_quiet("to_back_idle");
        stall = 1'b0;
        exp_frame(2, 8'hA5);
        req = 4'b0100;
        wait_quiet("to_next_grant");

        // Gap: pointer is 3, so 0 then 1 back to back
        exp_frame(0, 8'h11);
        exp_frame(1, 8'h22);
        req = 4'b0011;
        @(negedge clk);
        wait_ack(0, 20, "gap_first_ack");
        @(negedge clk);
        wait_ack(1, 500, "gap_second_ack");
        ack_cyc = cyc;
        // fall_cyc is the edge before the one sampling donetx low
        chk("gap_spacing", 32'(ack_cyc - fall_cyc), GapCycles + 2);
        wait_quiet("gap_complete");

        // Reset mid-frame, then a lone req[3] is granted on the next edge
        reset_mid_frame(1);
        exp_frame(3, 8'h44);
        req = 4'b1000;
        @(negedge clk);
        chk("rst_regrant_1cycle", 32'(ack), 32'b1000);
        wait_quiet("rst_regrant_complete");

        // Reset with pointer at 3 must restart the scan at 0
        reset_mid_frame(2);
        exp_frame(0, 8'h11);
        exp_frame(3, 8'h44);
        req = 4'b1001;
        @(negedge clk);
        chk("rst_ptr_zero", 32'(ack), 32'b0001);
        wait_quiet("rst_ptr_complete");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("frames_drained", 32'(frm_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
